// File: rtl/dac_pkg.sv
// dac_pkg -- shared widths and state encoding for the dual DAC7611 serializer.
// Revision 1.0
`default_nettype none

package dac_pkg;

  localparam int SAMPLE_W = 12;
  localparam int DIV_W    = 8;
  localparam int BIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } dac_state_t;

endpackage

`default_nettype wire

// File: rtl/dac_shift_lane.sv
// dac_shift_lane -- 12-bit parallel-load, left-shift register with serial MSB output.
// Revision 1.0
`default_nettype none

module dac_shift_lane
  import dac_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                load,
  input  logic                shift,
  input  logic [SAMPLE_W-1:0] din,
  output logic                msb
);

  logic [SAMPLE_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[SAMPLE_W-2:0], 1'b0};
    end
  end

  assign msb = sr[SAMPLE_W-1];

endmodule

`default_nettype wire

// File: rtl/dac_serializer.sv
// dac_serializer -- captures sample pairs and shifts them MSB-first into two DAC7611s.
// Revision 1.0
`default_nettype none

module dac_serializer
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned LEB_LOW = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [SAMPLE_W-1:0] sample_a,
  input  logic [SAMPLE_W-1:0] sample_b,
  input  logic                sample_valid,
  input  logic                overrun_clr,
  output logic                dac_clk,
  output logic                dac_dat_a,
  output logic                dac_dat_b,
  output logic                dac_leb,
  output logic                busy,
  output logic                overrun
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LEB_LAST = DIV_W'(LEB_LOW - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(SAMPLE_W - 1);

  dac_state_t          state, state_nx;
  logic [DIV_W-1:0]    cnt, cnt_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic                dac_clk_nx, dac_leb_nx, busy_nx, overrun_nx;
  logic                pend_full, pend_full_nx;
  logic [SAMPLE_W-1:0] pend_a, pend_a_nx, pend_b, pend_b_nx;
  logic                load, shift, use_pend, ovr_set;
  logic [SAMPLE_W-1:0] load_a, load_b;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      dac_clk   <= 1'b0;
      dac_leb   <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      pend_full <= 1'b0;
      pend_a    <= '0;
      pend_b    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      dac_clk   <= dac_clk_nx;
      dac_leb   <= dac_leb_nx;
      busy      <= busy_nx;
      overrun   <= overrun_nx;
      pend_full <= pend_full_nx;
      pend_a    <= pend_a_nx;
      pend_b    <= pend_b_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bit_cnt_nx   = bit_cnt;
    dac_clk_nx   = dac_clk;
    dac_leb_nx   = dac_leb;
    busy_nx      = busy;
    pend_full_nx = pend_full;
    pend_a_nx    = pend_a;
    pend_b_nx    = pend_b;
    load         = 1'b0;
    shift        = 1'b0;
    use_pend     = 1'b0;
    ovr_set      = 1'b0;

    case (state)
      IDLE: begin
        if (pend_full || sample_valid) begin
          load       = 1'b1;
          use_pend   = pend_full;
          state_nx   = SHIFT;
          cnt_nx     = '0;
          bit_cnt_nx = BIT_TOP;
          dac_clk_nx = 1'b0;
          busy_nx    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx     = '0;
          dac_clk_nx = ~dac_clk;
          // Falling dac_clk: advance to the next bit, or close the frame after bit 0.
          if (dac_clk) begin
            if (bit_cnt == '0) begin
              state_nx   = LOAD;
              dac_leb_nx = 1'b0;
            end else begin
              bit_cnt_nx = bit_cnt - 1'b1;
              shift      = 1'b1;
            end
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      LOAD: begin
        if (cnt == LEB_LAST) begin
          dac_leb_nx = 1'b1;
          cnt_nx     = '0;
          if (pend_full) begin
            load       = 1'b1;
            use_pend   = 1'b1;
            state_nx   = SHIFT;
            bit_cnt_nx = BIT_TOP;
          end else begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // A strobe is buffered unless it starts a frame straight from an empty IDLE;
    // it only counts as an overrun when the buffered pair is not consumed this cycle.
    if (sample_valid) begin
      if (!(load && !use_pend)) begin
        pend_a_nx    = sample_a;
        pend_b_nx    = sample_b;
        pend_full_nx = 1'b1;
        ovr_set      = pend_full && !use_pend;
      end
    end else if (use_pend) begin
      pend_full_nx = 1'b0;
    end

    overrun_nx = ovr_set | (overrun & ~overrun_clr);
  end

  assign load_a = use_pend ? pend_a : sample_a;
  assign load_b = use_pend ? pend_b : sample_b;

  dac_shift_lane u_lane_a (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (load),
    .shift (shift),
    .din   (load_a),
    .msb   (dac_dat_a)
  );

  dac_shift_lane u_lane_b (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (load),
    .shift (shift),
    .din   (load_b),
    .msb   (dac_dat_b)
  );

endmodule

`default_nettype wire
